// File: rtl/push_blinker.sv
// Turns one-cycle push strobes into fixed-length LED blinks (on-time, then forced off-gap).
// Pushes that arrive during a blink are queued and replayed in order, up to the queue depth.
module push_blinker #(
  parameter int ON_CYCLES     = 12500000,
  parameter int OFF_CYCLES    = 12500000,
  parameter int PENDING_WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     clear,
  output logic                     led,
  output logic                     busy,
  output logic [PENDING_WIDTH-1:0] pending,
  output logic                     overflow
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0]            ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]            OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PENDING_WIDTH-1:0] PEND_ONE = PENDING_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t                   state;
  logic [TW-1:0]            timer;
  logic                     off_done;
  logic [PENDING_WIDTH-1:0] pend_nxt;
  logic                     ovf_set;

  assign off_done = (state == S_OFF) && (timer == '0);

  // Queue bookkeeping. When the gap ends with work queued, a same-cycle push
  // cancels the dequeue; when it ends with nothing queued, that push starts
  // the next blink directly and never touches the queue.
  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    if (state != S_IDLE) begin
      if (off_done) begin
        if (pending != '0 && !push) pend_nxt = pending - PEND_ONE;
      end else if (push) begin
        if (pending == PEND_MAX) ovf_set  = 1'b1;
        else                     pend_nxt = pending + PEND_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= S_IDLE;
      timer    <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (ovf_set) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (push) begin
            state <= S_ON;
            timer <= ON_LOAD;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_ON: begin
          if (timer == '0) begin
            state <= S_OFF;
            timer <= OFF_LOAD;
            led   <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_OFF: begin
          if (timer == '0) begin
            if (pending != '0 || push) begin
              state <= S_ON;
              timer <= ON_LOAD;
              led   <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_push_blinker.sv
// Directed bench for push_blinker with ON=3, OFF=2, PENDING_WIDTH=2.
// Cycle k is the observation window just after clock edge k-1 (edge 0 = first edge after reset release).
module tb_push_blinker;

  localparam int PW = 2;
  localparam int NC = 40;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push  = 1'b0;
  logic          clear = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  logic          led_o  [0:NC];
  logic          busy_o [0:NC];
  logic          ovf_o  [0:NC];
  logic [PW-1:0] pend_o [0:NC];

  push_blinker #(.ON_CYCLES(3), .OFF_CYCLES(2), .PENDING_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .push(push), .clear(clear),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b0; push = 1'b0; clear = 1'b0;
    @(posedge clock); @(posedge clock);
    #2 reset = 1'b1;
  endtask

  // Drives push/clear masks (bit c sampled at edge c) and records outputs per cycle.
  task automatic run(input logic [63:0] pm, input logic [63:0] cm, input int n);
    do_reset();
    led_o[0] = led; busy_o[0] = busy; ovf_o[0] = overflow; pend_o[0] = pending;
    for (int c = 0; c < n; c++) begin
      push  = pm[c];
      clear = cm[c];
      @(posedge clock); #1;
      led_o[c+1] = led; busy_o[c+1] = busy; ovf_o[c+1] = overflow; pend_o[c+1] = pending;
    end
    push = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 1'b1; clear = 1'b0;
    @(posedge clock); #1;
    checks++; if (led !== 1'b0)      begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pending !== 2'd0)  begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    push = 1'b0;
  endtask

  task automatic test_single();
    logic el, eb;
    run(64'd1 << 10, 64'd0, 22);
    for (int c = 1; c <= 22; c++) begin
      el = (c >= 11 && c <= 13);
      eb = (c >= 11 && c <= 15);
      checks++; if (led_o[c] !== el)  begin failures++; $display("FAIL single_led c=%0d got=%b exp=%b", c, led_o[c], el); end
      checks++; if (busy_o[c] !== eb) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy_o[c], eb); end
      checks++; if (pend_o[c] !== 2'd0) begin failures++; $display("FAIL single_pend c=%0d got=%0d exp=0", c, pend_o[c]); end
    end
  endtask

  task automatic test_queue();
    logic el, eb;
    logic [PW-1:0] ep;
    run((64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12), 64'd0, 30);
    for (int c = 1; c <= 30; c++) begin
      el = (c >= 11 && c <= 13) || (c >= 16 && c <= 18) || (c >= 21 && c <= 23);
      eb = (c >= 11 && c <= 25);
      ep = (c == 12) ? 2'd1 : (c >= 13 && c <= 15) ? 2'd2 : (c >= 16 && c <= 20) ? 2'd1 : 2'd0;
      checks++; if (led_o[c] !== el)  begin failures++; $display("FAIL queue_led c=%0d got=%b exp=%b", c, led_o[c], el); end
      checks++; if (busy_o[c] !== eb) begin failures++; $display("FAIL queue_busy c=%0d got=%b exp=%b", c, busy_o[c], eb); end
      checks++; if (pend_o[c] !== ep) begin failures++; $display("FAIL queue_pend c=%0d got=%0d exp=%0d", c, pend_o[c], ep); end
      checks++; if (ovf_o[c] !== 1'b0) begin failures++; $display("FAIL queue_ovf c=%0d got=%b exp=0", c, ovf_o[c]); end
    end
  endtask

  task automatic test_overflow();
    logic el, eb, eo;
    logic [PW-1:0] ep;
    int blinks;
    run(64'h1F << 10, 64'd0, 36);
    blinks = 0;
    for (int c = 1; c <= 36; c++) begin
      el = (c >= 11 && c <= 13) || (c >= 16 && c <= 18) || (c >= 21 && c <= 23) || (c >= 26 && c <= 28);
      eb = (c >= 11 && c <= 30);
      eo = (c >= 15);
      ep = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c >= 14 && c <= 15) ? 2'd3 :
           (c >= 16 && c <= 20) ? 2'd2 : (c >= 21 && c <= 25) ? 2'd1 : 2'd0;
      if (led_o[c] === 1'b1 && led_o[c-1] !== 1'b1) blinks++;
      checks++; if (led_o[c] !== el)  begin failures++; $display("FAIL ovf_led c=%0d got=%b exp=%b", c, led_o[c], el); end
      checks++; if (busy_o[c] !== eb) begin failures++; $display("FAIL ovf_busy c=%0d got=%b exp=%b", c, busy_o[c], eb); end
      checks++; if (pend_o[c] !== ep) begin failures++; $display("FAIL ovf_pend c=%0d got=%0d exp=%0d", c, pend_o[c], ep); end
      checks++; if (ovf_o[c] !== eo)  begin failures++; $display("FAIL ovf_flag c=%0d got=%b exp=%b", c, ovf_o[c], eo); end
    end
    checks++; if (blinks != 4) begin failures++; $display("FAIL ovf_blink_count got=%0d exp=4", blinks); end
  endtask

  task automatic test_back_to_back();
    logic el, eb;
    run((64'd1 << 10) | (64'd1 << 15), 64'd0, 24);
    for (int c = 1; c <= 24; c++) begin
      el = (c >= 11 && c <= 13) || (c >= 16 && c <= 18);
      eb = (c >= 11 && c <= 20);
      checks++; if (led_o[c] !== el)  begin failures++; $display("FAIL b2b_led c=%0d got=%b exp=%b", c, led_o[c], el); end
      checks++; if (busy_o[c] !== eb) begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy_o[c], eb); end
      checks++; if (pend_o[c] !== 2'd0) begin failures++; $display("FAIL b2b_pend c=%0d got=%0d exp=0", c, pend_o[c]); end
    end
  endtask

  task automatic test_clear();
    logic el, eb;
    logic [PW-1:0] ep;
    run(64'hF << 10, 64'd1 << 13, 32);
    for (int c = 1; c <= 32; c++) begin
      el = (c >= 11 && c <= 13);
      eb = el;
      ep = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : 2'd0;
      checks++; if (led_o[c] !== el)  begin failures++; $display("FAIL clear_led c=%0d got=%b exp=%b", c, led_o[c], el); end
      checks++; if (busy_o[c] !== eb) begin failures++; $display("FAIL clear_busy c=%0d got=%b exp=%b", c, busy_o[c], eb); end
      checks++; if (pend_o[c] !== ep) begin failures++; $display("FAIL clear_pend c=%0d got=%0d exp=%0d", c, pend_o[c], ep); end
      checks++; if (ovf_o[c] !== 1'b0) begin failures++; $display("FAIL clear_ovf c=%0d got=%b exp=0", c, ovf_o[c]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      push = (c == 10);
      @(posedge clock); #1;
    end
    push = 1'b1;                 // second push sampled at edge 11, queued
    @(posedge clock); #1;        // now in cycle 12
    push = 1'b0;
    checks++; if (led !== 1'b1)     begin failures++; $display("FAIL ar_pre_led got=%b exp=1", led); end
    checks++; if (pending !== 2'd1) begin failures++; $display("FAIL ar_pre_pend got=%0d exp=1", pending); end
    #2 reset = 1'b0;
    #1;                          // still before edge 12
    checks++; if (led !== 1'b0)     begin failures++; $display("FAIL ar_led got=%b exp=0", led); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
    checks++; if (pending !== 2'd0) begin failures++; $display("FAIL ar_pend got=%0d exp=0", pending); end
    for (int c = 12; c < 15; c++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    for (int c = 15; c < 21; c++) begin
      push = (c == 20);
      @(posedge clock); #1;
      if (c < 20) begin
        checks++; if (led !== 1'b0) begin failures++; $display("FAIL ar_idle_led c=%0d got=%b exp=0", c + 1, led); end
      end
    end
    push = 1'b0;
    checks++; if (led !== 1'b1)  begin failures++; $display("FAIL ar_restart_led got=%b exp=1", led); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_restart_busy got=%b exp=1", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
